// File: rtl/dwt_pkg.sv
// Shared types and helpers for the streaming two-band DWT filter.
package dwt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVEN = 2'd1,
        ODD  = 2'd2,
        PAD  = 2'd3
    } state_t;

    localparam logic BANK_H = 1'b0;
    localparam logic BANK_G = 1'b1;

    localparam int STAGES = 2;

    function automatic int acc_width(input int dw, input int cw, input int taps);
        return dw + cw + $clog2(taps);
    endfunction

endpackage

// File: rtl/dwt_mac_bank.sv
// One filter bank: registered full-precision dot product, then round half-up and saturate.
module dwt_mac_bank
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 6,
    parameter int FRAC_BITS  = 14
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                en,
    input  logic [TAPS-1:0][DATA_WIDTH-1:0]     hist,
    input  logic [TAPS-1:0][COEF_WIDTH-1:0]     coef,
    output logic [DATA_WIDTH-1:0]               result
);

    localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH, TAPS);
    localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    logic signed [PROD_W-1:0] prod [TAPS];
    logic signed [ACC_W-1:0]  sum, acc, rnd, shf;

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        assign prod[k] = PROD_W'($signed(hist[k])) * PROD_W'($signed(coef[k]));
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) sum = sum + ACC_W'(prod[k]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     acc <= '0;
        else if (en) acc <= sum;
    end

    always_comb begin
        rnd = acc + HALF;
        shf = rnd >>> FRAC_BITS;
        if (shf > MAXV)      result = MAXV[DATA_WIDTH-1:0];
        else if (shf < MINV) result = MINV[DATA_WIDTH-1:0];
        else                 result = shf[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/dwt_stream.sv
// Streaming one-level DWT: sample pairs in, (approx, detail) pairs out, odd frames zero-padded.
module dwt_stream
    import dwt_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int COEF_WIDTH = 16,
    parameter int TAPS       = 6,
    parameter int FRAC_BITS  = 14
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        coef_wr,
    input  logic                        coef_bank,
    input  logic [$clog2(TAPS)-1:0]     coef_addr,
    input  logic [COEF_WIDTH-1:0]       coef_data,
    output logic                        coef_ready,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_last,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH-1:0]       m_approx,
    output logic [DATA_WIDTH-1:0]       m_detail,
    output logic                        m_last
);

    state_t state, state_nxt;

    logic [1:0][TAPS-1:0][COEF_WIDTH-1:0] coef;
    logic [TAPS-1:0][DATA_WIDTH-1:0]      hist, hist_nxt;
    logic [1:0][DATA_WIDTH-1:0]           res;
    logic [STAGES:0]                      vld_pipe;
    logic [STAGES-1:0]                    last_pipe;

    logic accept, go_pad, launch, launch_last, stall1, s1_load, out_load;

    // vld_pipe[0] marks a pair whose window sits in hist, waiting for stage 1
    assign out_load = !vld_pipe[2] || m_ready;
    assign stall1   = vld_pipe[1] && !out_load;
    assign s1_load  = !stall1;
    assign m_valid  = vld_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, EVEN: if (accept) state_nxt = s_last ? PAD : ODD;
            ODD:        if (accept) state_nxt = s_last ? IDLE : EVEN;
            PAD:        if (go_pad) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        coef_ready  = (state == IDLE);
        s_ready     = (state != PAD) && !stall1;
        accept      = s_valid && s_ready;
        go_pad      = (state == PAD) && !stall1;
        launch      = ((state == ODD) && accept) || go_pad;
        launch_last = (state == PAD) || s_last;
    end

    // A frame start shifts into an all-zero history.
    always_comb begin
        hist_nxt[0] = (state == PAD) ? '0 : s_data;
        for (int k = 1; k < TAPS; k++) hist_nxt[k] = (state == IDLE) ? '0 : hist[k-1];
    end

    // In IDLE the history is cleared once any pending pair has copied it into stage 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                             hist <= '0;
        else if (accept || go_pad)           hist <= hist_nxt;
        else if (state == IDLE && !stall1)   hist <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           coef <= '0;
        else if (coef_wr && state == IDLE) coef[coef_bank][coef_addr] <= coef_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
            m_approx  <= '0;
            m_detail  <= '0;
            m_last    <= 1'b0;
        end else begin
            if (launch) begin
                vld_pipe[0]  <= 1'b1;
                last_pipe[0] <= launch_last;
            end else if (s1_load) begin
                vld_pipe[0]  <= 1'b0;
            end
            if (s1_load) begin
                vld_pipe[1]  <= vld_pipe[0];
                last_pipe[1] <= last_pipe[0];
            end
            if (out_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    m_approx <= res[BANK_H];
                    m_detail <= res[BANK_G];
                    m_last   <= last_pipe[1];
                end
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dwt_mac_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .COEF_WIDTH (COEF_WIDTH),
            .TAPS       (TAPS),
            .FRAC_BITS  (FRAC_BITS)
        ) u_mac (
            .clk    (clk),
            .rst    (rst),
            .en     (s1_load && vld_pipe[0]),
            .hist   (hist),
            .coef   (coef[b]),
            .result (res[b])
        );
    end

endmodule

// File: tb/tb_dwt_stream.sv
// Directed bench for dwt_stream with TAPS=2, FRAC_BITS=8.
module tb_dwt_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        coef_wr = 1'b0;
    logic        coef_bank = 1'b0;
    logic [0:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        coef_ready;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [15:0] m_approx, m_detail;
    logic        m_last;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic signed [15:0] a;
        logic signed [15:0] d;
        logic               l;
    } pair_t;
    pair_t q[$];

    typedef struct {
        int h0, h1, g0, g1;
        int x0, x1;
        int ea, ed;
    } vec_t;
    vec_t vt[7];

    dwt_stream #(
        .DATA_WIDTH (16),
        .COEF_WIDTH (16),
        .TAPS       (2),
        .FRAC_BITS  (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_wr    (coef_wr),
        .coef_bank  (coef_bank),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_approx   (m_approx),
        .m_detail   (m_detail),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && m_valid && m_ready)
            q.push_back('{$signed(m_approx), $signed(m_detail), m_last});

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic longint ref_out(input int c0, input int c1, input int xn, input int xo);
        longint s;
        s = longint'(c0) * xn + longint'(c1) * xo + 128;
        s = s >>> 8;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        return s;
    endfunction

    task automatic wr(input logic b, input logic a, input int d);
        coef_wr   = 1'b1;
        coef_bank = b;
        coef_addr = a;
        coef_data = 16'(d);
        @(posedge clk); #1;
        coef_wr   = 1'b0;
    endtask

    task automatic set_coefs(input int h0, input int h1, input int g0, input int g1);
        wr(1'b0, 1'b0, h0);
        wr(1'b0, 1'b1, h1);
        wr(1'b1, 1'b0, g0);
        wr(1'b1, 1'b1, g1);
    endtask

    task automatic send(input int d, input logic l);
        int t = 0;
        s_valid = 1'b1;
        s_data  = 16'(d);
        s_last  = l;
        @(negedge clk);
        while (!s_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) check("send_timeout", 0, 1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_pairs(input int n, input string name);
        int t = 0;
        while (q.size() < n && t < 300) begin
            @(posedge clk);
            t++;
        end
        #1;
        repeat (4) @(posedge clk);
        #1;
        check(name, q.size(), n);
    endtask

    task automatic check_pair(input string name, input int idx, input int ea, input int ed, input int el);
        if (idx < q.size()) begin
            check({name, "_approx"}, q[idx].a, ea);
            check({name, "_detail"}, q[idx].d, ed);
            check({name, "_last"},   q[idx].l, el);
        end else begin
            check({name, "_missing"}, idx, -1);
        end
    endtask

    initial begin
        vt[0] = '{128, 128, 128, -128,     10,     20,     15,  5};
        vt[1] = '{255, 255, 128, -128,  32767,  32767,  32767,  0};
        vt[2] = '{128, 128, 128, -128,      1,      0,      1,  0};
        vt[3] = '{255, 255, 128, -128, -32768, -32768, -32768,  0};
        vt[4] = '{256,   0,   0,  256,    300,     -7,     -7, 300};
        vt[5] = '{128,   0,   0,  -64,      5,     -3,     -1, -1};
        vt[6] = '{-256,  0, 32767,  0,      0,  32767, -32767, 32767};

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid",    m_valid, 0);
        check("rst_m_approx",   m_approx, 0);
        check("rst_m_detail",   m_detail, 0);
        check("rst_m_last",     m_last, 0);
        check("rst_s_ready",    s_ready, 1);
        check("rst_coef_ready", coef_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: two-sample frames, exact latency and values.
        for (int i = 0; i < 7; i++) begin
            set_coefs(vt[i].h0, vt[i].h1, vt[i].g0, vt[i].g1);
            q.delete();
            send(vt[i].x0, 1'b0);
            send(vt[i].x1, 1'b1);
            check($sformatf("v%0d_lat0", i), m_valid, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_lat1", i), m_valid, 0);
            @(posedge clk); #1;
            check($sformatf("v%0d_lat2", i), m_valid, 1);
            check($sformatf("v%0d_approx", i), $signed(m_approx), vt[i].ea);
            check($sformatf("v%0d_detail", i), $signed(m_detail), vt[i].ed);
            check($sformatf("v%0d_last", i), m_last, 1);
            @(posedge clk); #1;
            check($sformatf("v%0d_drain", i), m_valid, 0);
        end

        // Odd frame: padded final pair.
        set_coefs(128, 128, 128, -128);
        q.delete();
        send(10, 1'b0);
        send(20, 1'b0);
        send(30, 1'b1);
        check("odd_pad_s_ready", s_ready, 0);
        check("odd_pad_coef_ready", coef_ready, 0);
        wait_pairs(2, "odd_count");
        check_pair("odd_p0", 0, 15, 5, 0);
        check_pair("odd_p1", 1, 15, -15, 1);

        // Backpressure through a 16-sample frame.
        begin
            logic saw_low = 1'b0;
            int   xs[16];
            for (int i = 0; i < 16; i++) xs[i] = 1000 * i - 7000 + 3 * i * i;
            q.delete();
            fork
                begin
                    for (int i = 0; i < 16; i++) send(xs[i], i == 15);
                end
                begin
                    repeat (5) @(posedge clk);
                    #1;
                    m_ready = 1'b0;
                    repeat (10) begin
                        @(negedge clk);
                        if (!s_ready) saw_low = 1'b1;
                    end
                    @(posedge clk); #1;
                    m_ready = 1'b1;
                end
            join
            wait_pairs(8, "bp_count");
            check("bp_s_ready_fell", saw_low, 1);
            for (int j = 0; j < 8; j++)
                check_pair($sformatf("bp_p%0d", j), j,
                           int'(ref_out(128, 128, xs[2*j+1], xs[2*j])),
                           int'(ref_out(128, -128, xs[2*j+1], xs[2*j])),
                           j == 7);
        end

        // Reset mid-frame while an output is held.
        begin
            int t = 0;
            m_ready = 1'b0;
            send(1000, 1'b0);
            send(2000, 1'b0);
            send(3000, 1'b0);
            while (!m_valid && t < 50) begin
                @(posedge clk); #1;
                t++;
            end
            check("rstmid_m_valid_before", m_valid, 1);
            rst = 1'b1;
            #1;
            check("rstmid_m_valid", m_valid, 0);
            check("rstmid_m_approx", m_approx, 0);
            check("rstmid_coef_ready", coef_ready, 1);
            check("rstmid_s_ready", s_ready, 1);
            @(posedge clk);
            @(posedge clk); #1;
            rst = 1'b0;
            m_ready = 1'b1;
            @(posedge clk); #1;
            q.delete();
            set_coefs(128, 128, 128, -128);
            send(10, 1'b0);
            send(20, 1'b1);
            wait_pairs(1, "rstmid_count");
            check_pair("rstmid_p0", 0, 15, 5, 1);
        end

        // Coefficient write outside IDLE must be ignored.
        q.delete();
        send(10, 1'b0);
        coef_wr   = 1'b1;
        coef_bank = 1'b0;
        coef_addr = 1'b0;
        coef_data = 16'd0;
        #1;
        check("odd_coef_ready", coef_ready, 0);
        @(posedge clk); #1;
        coef_wr = 1'b0;
        send(20, 1'b1);
        wait_pairs(1, "cwr_count");
        check_pair("cwr_p0", 0, 15, 5, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
